lcd_fifo_writer: RTL and testbench

Consumer stage behind the initialization FIFO: pops one byte at a time from the FIFO read port and writes it to an HD44780-compatible character LCD in 8-bit mode. Bytes `0..NUM_CMD-1` after reset are commands (RS=0); all later bytes are display data (RS=1). Drives RS, E and DB with parameterised setup, enable-pulse, hold and execution-wait intervals, and reports Busy upstream.

---
 rtl/lcd_fifo_writer.sv | 211 +++++++++++++++++++++
 tb/tb_lcd_fifo_writer.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/lcd_fifo_writer.sv
// lcd_fifo_writer
//
// Consumer stage behind the LCD initialization FIFO. Pops one byte at a time and writes it
// to an HD44780-compatible character LCD in 8-bit mode. The first NUM_CMD bytes after reset
// are sent as commands (RS=0); every later byte is display data (RS=1). Each byte goes
// through a setup / enable-pulse / hold / execution-wait sequence with parameterised lengths.
//
// Optional feature macro: LCD_LONG_WAIT_EN
//   Defined:   Clear (8'h01) and Home (8'h02/8'h03) sent as commands wait T_LONG cycles.
//   Undefined: every byte waits T_WAIT cycles.
//
// Ports:
//   clk        in   system clock, rising edge
//   rst        in   synchronous active-low reset
//   fifo_empty in   FIFO empty flag, sampled only while idle
//   fifo_dout  in   FIFO read data, valid the cycle after rd_en1
//   rd_en1     out  FIFO pop strobe, one cycle per byte
//   LCD_RS     out  register select (0 = command, 1 = data)
//   LCD_RW     out  tied low, write only
//   LCD_E      out  enable strobe
//   LCD_DB     out  8-bit LCD data bus
//   Busy       out  high whenever a byte is in flight
//   byte_cnt   out  bytes written since reset, saturates at 255
//
// All outputs are registered so E and the bus never glitch on state decode.

module lcd_fifo_writer #(
  parameter int unsigned NUM_CMD = 4,
  parameter int unsigned T_SETUP = 2,
  parameter int unsigned T_PULSE = 12,
  parameter int unsigned T_HOLD  = 2,
  parameter int unsigned T_WAIT  = 2000,
  parameter int unsigned T_LONG  = 82000,
  parameter int unsigned CW      = 20
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       fifo_empty,
  input  logic [7:0] fifo_dout,
  output logic       rd_en1,
  output logic       LCD_RS,
  output logic       LCD_RW,
  output logic       LCD_E,
  output logic [7:0] LCD_DB,
  output logic       Busy,
  output logic [7:0] byte_cnt
);

  // A zero-length interval would underflow the load value, so it is stretched to one cycle.
  localparam int unsigned SetupEff = (T_SETUP == 0) ? 1 : T_SETUP;
  localparam int unsigned PulseEff = (T_PULSE == 0) ? 1 : T_PULSE;
  localparam int unsigned HoldEff  = (T_HOLD  == 0) ? 1 : T_HOLD;
  localparam int unsigned WaitEff  = (T_WAIT  == 0) ? 1 : T_WAIT;
  localparam int unsigned LongEff  = (T_LONG  == 0) ? 1 : T_LONG;

  // Counter load values: a timed state lasts (load + 1) cycles.
  localparam logic [CW-1:0] SetupLd = CW'(SetupEff - 1);
  localparam logic [CW-1:0] PulseLd = CW'(PulseEff - 1);
  localparam logic [CW-1:0] HoldLd  = CW'(HoldEff - 1);
  localparam logic [CW-1:0] WaitLd  = CW'(WaitEff - 1);
  localparam logic [CW-1:0] LongLd  = CW'(LongEff - 1);

  typedef enum logic [2:0] {
    StIdle,
    StRead,
    StLatch,
    StSetup,
    StPulse,
    StHold,
    StWait
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [CW-1:0] wait_ld_q, wait_ld_d;
  logic          rs_q, rs_d;
  logic [7:0]    db_q, db_d;
  logic [7:0]    byte_cnt_q, byte_cnt_d;
  logic          e_q, e_d;
  logic          rd_q, rd_d;
  logic          busy_q, busy_d;

  // Pre-increment count decides command vs data, so byte index NUM_CMD is the first data byte.
  logic cmd_byte;
  assign cmd_byte = ({24'd0, byte_cnt_q} < NUM_CMD);

  // Selects the long execution wait for the byte currently on fifo_dout.
  logic long_sel;
`ifdef LCD_LONG_WAIT_EN
  assign long_sel = cmd_byte &&
                    ((fifo_dout == 8'h01) || (fifo_dout == 8'h02) || (fifo_dout == 8'h03));
`else
  assign long_sel = 1'b0;
`endif

  logic cnt_done;
  assign cnt_done = (cnt_q == '0);

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    wait_ld_d  = wait_ld_q;
    rs_d       = rs_q;
    db_d       = db_q;
    byte_cnt_d = byte_cnt_q;

    unique case (state_q)
      StIdle: begin
        if (!fifo_empty) begin
          state_d = StRead;
        end
      end

      // rd_en1 is high for this single cycle; data arrives during StLatch.
      StRead: begin
        state_d = StLatch;
      end

      StLatch: begin
        db_d      = fifo_dout;
        rs_d      = ~cmd_byte;
        wait_ld_d = long_sel ? LongLd : WaitLd;
        if (byte_cnt_q != 8'hFF) begin
          byte_cnt_d = byte_cnt_q + 8'd1;
        end
        cnt_d   = SetupLd;
        state_d = StSetup;
      end

      StSetup: begin
        if (cnt_done) begin
          cnt_d   = PulseLd;
          state_d = StPulse;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end

      StPulse: begin
        if (cnt_done) begin
          cnt_d   = HoldLd;
          state_d = StHold;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end

      StHold: begin
        if (cnt_done) begin
          cnt_d   = wait_ld_q;
          state_d = StWait;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end

      StWait: begin
        if (cnt_done) begin
          state_d = StIdle;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end

      default: begin
        cnt_d   = '0;
        state_d = StIdle;
      end
    endcase
  end

  // Outputs follow the next state so they line up with the state register without decode glitches.
  always_comb begin
    e_d    = (state_d == StPulse);
    rd_d   = (state_d == StRead);
    busy_d = (state_d != StIdle);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      wait_ld_q  <= '0;
      rs_q       <= 1'b0;
      db_q       <= 8'h00;
      byte_cnt_q <= 8'h00;
      e_q        <= 1'b0;
      rd_q       <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      wait_ld_q  <= wait_ld_d;
      rs_q       <= rs_d;
      db_q       <= db_d;
      byte_cnt_q <= byte_cnt_d;
      e_q        <= e_d;
      rd_q       <= rd_d;
      busy_q     <= busy_d;
    end
  end

  assign rd_en1   = rd_q;
  assign LCD_RS   = rs_q;
  assign LCD_RW   = 1'b0;
  assign LCD_E    = e_q;
  assign LCD_DB   = db_q;
  assign Busy     = busy_q;
  assign byte_cnt = byte_cnt_q;

endmodule

// File: tb/tb_lcd_fifo_writer.sv
// Testbench for lcd_fifo_writer with short intervals (setup 2, pulse 4, hold 2, wait 10,
// long wait 50). A small FIFO model feeds the DUT; a negedge monitor logs E edges, RS/DB at
// each E rise, rd_en1 pulses and returns to idle, which the checks compare to hand values.

module tb_lcd_fifo_writer;

  localparam int TSetup = 2;
  localparam int TPulse = 4;
  localparam int THold  = 2;
  localparam int TWait  = 10;
  localparam int TLong  = 50;
`ifdef LCD_LONG_WAIT_EN
  localparam int LW = TLong;
`else
  localparam int LW = TWait;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       fifo_empty;
  logic [7:0] fifo_dout = 8'h00;
  logic       rd_en1;
  logic       LCD_RS;
  logic       LCD_RW;
  logic       LCD_E;
  logic [7:0] LCD_DB;
  logic       Busy;
  logic [7:0] byte_cnt;

  always #5 clk = ~clk;

  lcd_fifo_writer #(
    .NUM_CMD(4),
    .T_SETUP(TSetup),
    .T_PULSE(TPulse),
    .T_HOLD (THold),
    .T_WAIT (TWait),
    .T_LONG (TLong),
    .CW     (20)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .fifo_empty(fifo_empty),
    .fifo_dout (fifo_dout),
    .rd_en1    (rd_en1),
    .LCD_RS    (LCD_RS),
    .LCD_RW    (LCD_RW),
    .LCD_E     (LCD_E),
    .LCD_DB    (LCD_DB),
    .Busy      (Busy),
    .byte_cnt  (byte_cnt)
  );

  // FIFO model: written by the stimulus, popped on rd_en1, data valid the following cycle.
  logic [7:0] mem [64];
  int wr_cnt = 0;
  int rd_cnt = 0;
  assign fifo_empty = (wr_cnt == rd_cnt);

  always @(posedge clk) begin
    if (rd_en1 && (wr_cnt != rd_cnt)) begin
      fifo_dout <= mem[rd_cnt[5:0]];
      rd_cnt    <= rd_cnt + 1;
    end
  end

  // Event monitor, sampled on the falling edge.
  int         cyc = 0;
  int         n_rise = 0;
  int         n_idle = 0;
  int         n_rd = 0;
  int         rise_cyc [64];
  int         fall_cyc [64];
  int         idle_cyc [64];
  int         rd_cyc [64];
  logic       rise_rs [64];
  logic [7:0] rise_db [64];
  logic       e_prev = 1'b0;
  logic       busy_prev = 1'b0;

  always @(negedge clk) begin
    cyc       <= cyc + 1;
    e_prev    <= LCD_E;
    busy_prev <= Busy;
    if (LCD_E && !e_prev && n_rise < 64) begin
      rise_cyc[n_rise] <= cyc;
      rise_rs[n_rise]  <= LCD_RS;
      rise_db[n_rise]  <= LCD_DB;
      n_rise           <= n_rise + 1;
    end
    if (!LCD_E && e_prev && n_rise > 0) begin
      fall_cyc[n_rise-1] <= cyc;
    end
    if (!Busy && busy_prev && n_idle < 64) begin
      idle_cyc[n_idle] <= cyc;
      n_idle           <= n_idle + 1;
    end
    if (rd_en1 && n_rd < 64) begin
      rd_cyc[n_rd] <= cyc;
      n_rd         <= n_rd + 1;
    end
  end

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic push(input logic [7:0] b);
    mem[wr_cnt[5:0]] = b;
    wr_cnt = wr_cnt + 1;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Waits until the FIFO is drained and the DUT is idle, then lets the monitor settle.
  task automatic wait_done(input string tag);
    bit done = 1'b0;
    for (int i = 0; i < 2000 && !done; i++) begin
      step();
      if (fifo_empty && !Busy) done = 1'b1;
    end
    check({"timeout_", tag}, int'(done), 1);
    step();
  endtask

  task automatic do_reset();
    rst = 1'b0;
    step();
    step();
    rst = 1'b1;
  endtask

  typedef struct {
    logic [7:0] din;
    int         exp_rs;
    int         exp_wait;
  } vec_t;

  vec_t vecs [7];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int  r0, rb, ib, ab, busy_seen;
    bit  found;

    vecs[0] = '{8'h38, 0, TWait};
    vecs[1] = '{8'h0C, 0, TWait};
    vecs[2] = '{8'h01, 0, LW};
    vecs[3] = '{8'h06, 0, TWait};
    vecs[4] = '{8'h4B, 1, TWait};
    vecs[5] = '{8'h48, 1, TWait};
    vecs[6] = '{8'h01, 1, TWait};

    // Reset held with a non-empty FIFO, then released.
    rst = 1'b0;
    push(8'h38);
    for (int i = 0; i < 3; i++) begin
      step();
      check("rst_rd_en1", int'(rd_en1), 0);
    end
    check("rst_e", int'(LCD_E), 0);
    check("rst_rs", int'(LCD_RS), 0);
    check("rst_rw", int'(LCD_RW), 0);
    check("rst_db", int'(LCD_DB), 0);
    check("rst_busy", int'(Busy), 0);
    check("rst_byte_cnt", int'(byte_cnt), 0);
    check("rst_no_pop", rd_cnt, 0);
    rst = 1'b1;
    r0 = n_rd;
    step();
    check("rel_rd_en1_high", int'(rd_en1), 1);
    step();
    check("rel_rd_en1_low", int'(rd_en1), 0);
    wait_done("s1");
    check("s1_one_pop", n_rd - r0, 1);
    check("s1_period", idle_cyc[n_idle-1] - rd_cyc[n_rd-1], 2 + TSetup + TPulse + THold + TWait);
    check("s1_e_width", fall_cyc[n_rise-1] - rise_cyc[n_rise-1], TPulse);
    check("s1_rs", int'(rise_rs[n_rise-1]), 0);
    check("s1_db", int'(rise_db[n_rise-1]), 8'h38);
    check("s1_byte_cnt", int'(byte_cnt), 1);

    // Full init sequence plus Clear sent as data, table driven.
    do_reset();
    rb = n_rise;
    ib = n_idle;
    for (int i = 0; i < 6; i++) push(vecs[i].din);
    wait_done("s2a");
    check("s2_byte_cnt6", int'(byte_cnt), 6);
    check("s2_busy_idle", int'(Busy), 0);
    check("s2_rise_spacing", rise_cyc[rb+1] - rise_cyc[rb], 3 + TSetup + TPulse + THold + TWait);
    push(vecs[6].din);
    wait_done("s2b");
    check("s2_byte_cnt7", int'(byte_cnt), 7);
    check("s2_pulses", n_rise - rb, 7);
    for (int i = 0; i < 7; i++) begin
      check($sformatf("s2_rs_%0d", i), int'(rise_rs[rb+i]), vecs[i].exp_rs);
      check($sformatf("s2_db_%0d", i), int'(rise_db[rb+i]), int'(vecs[i].din));
      check($sformatf("s2_width_%0d", i), fall_cyc[rb+i] - rise_cyc[rb+i], TPulse);
      check($sformatf("s2_wait_%0d", i), idle_cyc[ib+i] - fall_cyc[rb+i] - THold,
            vecs[i].exp_wait);
    end

    // Reset during the second PULSE cycle.
    do_reset();
    push(8'h38);
    push(8'h0C);
    found = 1'b0;
    for (int i = 0; i < 100 && !found; i++) begin
      step();
      if (LCD_E) found = 1'b1;
    end
    check("s5_e_seen", int'(found), 1);
    step();
    rst = 1'b0;
    step();
    check("s5_e_low", int'(LCD_E), 0);
    check("s5_busy_low", int'(Busy), 0);
    check("s5_byte_cnt", int'(byte_cnt), 0);
    check("s5_fifo_left", wr_cnt - rd_cnt, 1);
    step();
    ab = n_rise - 1;
    rst = 1'b1;
    wait_done("s5");
    check("s5_cut_width", fall_cyc[ab] - rise_cyc[ab], 2);
    check("s5_next_db", int'(rise_db[n_rise-1]), 8'h0C);
    check("s5_next_rs", int'(rise_rs[n_rise-1]), 0);
    check("s5_byte_cnt_after", int'(byte_cnt), 1);

    // FIFO runs dry after byte index 3, refills 30 cycles later.
    do_reset();
    rb = n_rise;
    push(8'h38);
    push(8'h0C);
    push(8'h01);
    push(8'h06);
    wait_done("s6a");
    check("s6_busy_stall", int'(Busy), 0);
    r0 = n_rd;
    busy_seen = 0;
    repeat (30) begin
      step();
      if (Busy) busy_seen++;
    end
    check("s6_idle_during_stall", busy_seen, 0);
    check("s6_no_pop_stall", n_rd - r0, 0);
    push(8'h4B);
    wait_done("s6b");
    check("s6_byte3_rs", int'(rise_rs[rb+3]), 0);
    check("s6_byte4_rs", int'(rise_rs[rb+4]), 1);
    check("s6_byte4_db", int'(rise_db[rb+4]), 8'h4B);
    check("s6_byte_cnt", int'(byte_cnt), 5);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
